// File: rtl/fpu.sv
// Binary32 FPU slice: multiply, floor, floor-to-int and compare, denormals flushed to zero.
// Combinational compute into one result register: 1-cycle latency, a new op every cycle.
module fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  fpu_op,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_FLOOR = 3'd1,
    OP_F2I   = 3'd2,
    OP_CMP   = 3'd3
  } op_e;

  logic [31:0] r_result;
  logic [31:0] w_next;

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  assign w_sa     = a[31];
  assign w_sb     = b[31];
  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_ma     = a[22:0];
  assign w_mb     = b[22:0];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);

  // Multiply: exact 48-bit product, one-place normalise, RNE on the dropped bits.
  logic [47:0] w_prod;
  logic        w_norm, w_guard, w_sticky, w_rnd_up, w_mul_s;
  logic [22:0] w_mant_pre;
  logic [23:0] w_mant_rnd;
  logic [9:0]  w_mul_exp;
  logic [31:0] w_mul_val;

  assign w_prod     = {24'd0, 1'b1, w_ma} * {24'd0, 1'b1, w_mb};
  assign w_norm     = w_prod[47];
  assign w_mant_pre = w_norm ? w_prod[46:24] : w_prod[45:23];
  assign w_guard    = w_norm ? w_prod[23] : w_prod[22];
  assign w_sticky   = w_norm ? (|w_prod[22:0]) : (|w_prod[21:0]);
  assign w_rnd_up   = w_guard & (w_sticky | w_mant_pre[0]);
  assign w_mant_rnd = {1'b0, w_mant_pre} + {23'd0, w_rnd_up};
  assign w_mul_s    = w_sa ^ w_sb;
  // 10-bit wrap: bit 9 set means the biased exponent went negative.
  assign w_mul_exp  = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127
                    + {9'd0, w_norm} + {9'd0, w_mant_rnd[23]};

  always_comb begin
    w_mul_val = {w_mul_s, w_mul_exp[7:0], w_mant_rnd[22:0]};
    if (w_a_nan || w_b_nan)
      w_mul_val = QNAN;
    else if (w_a_inf || w_b_inf)
      w_mul_val = (w_a_zero || w_b_zero) ? QNAN : {w_mul_s, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      w_mul_val = {w_mul_s, 31'd0};
    else if (w_mul_exp[9] || (w_mul_exp == 10'd0))
      w_mul_val = {w_mul_s, 31'd0};
    else if (w_mul_exp >= 10'd255)
      w_mul_val = {w_mul_s, 8'hFF, 23'd0};
  end

  // Unbiased exponent, only meaningful for ea in 127..157; 127 == 31 mod 32.
  logic [4:0]  w_ue;
  assign w_ue = w_ea[4:0] - 5'd31;

  logic [22:0] w_fl_mask, w_fl_trunc;
  logic        w_fl_frac;
  logic [24:0] w_fl_unit, w_fl_sum;
  logic [31:0] w_floor_val;

  assign w_fl_mask  = 23'h7FFFFF >> w_ue;
  assign w_fl_trunc = w_ma & ~w_fl_mask;
  assign w_fl_frac  = |(w_ma & w_fl_mask);
  assign w_fl_unit  = {2'b00, w_fl_mask} + 25'd1;
  assign w_fl_sum   = {2'b01, w_fl_trunc} + w_fl_unit;

  always_comb begin
    w_floor_val = {w_sa, w_ea, w_fl_trunc};
    if (w_a_nan)
      w_floor_val = QNAN;
    else if (w_a_inf || (w_ea >= 8'd150))
      w_floor_val = a;
    else if (w_a_zero)
      w_floor_val = {w_sa, 31'd0};
    else if (w_ea < 8'd127)
      w_floor_val = w_sa ? 32'hBF800000 : 32'h0;
    else if (w_sa && w_fl_frac)
      w_floor_val = {1'b1, w_ea + {7'd0, w_fl_sum[24]},
                     w_fl_sum[24] ? w_fl_sum[23:1] : w_fl_sum[22:0]};
  end

  logic [53:0] w_fi_sh;
  logic        w_fi_frac;
  logic [31:0] w_fi_mag, w_fi_val;

  assign w_fi_sh   = {30'd0, 1'b1, w_ma} << w_ue;
  assign w_fi_frac = |w_fi_sh[22:0];
  assign w_fi_mag  = {1'b0, w_fi_sh[53:23]} + {31'd0, w_sa & w_fi_frac};

  always_comb begin
    w_fi_val = w_sa ? (32'd0 - w_fi_mag) : w_fi_mag;
    if (w_a_nan || w_a_zero)
      w_fi_val = 32'h0;
    else if (w_ea >= 8'd158)
      w_fi_val = w_sa ? 32'h80000000 : 32'h7FFFFFFF;
    else if (w_ea < 8'd127)
      w_fi_val = w_sa ? 32'hFFFFFFFF : 32'h0;
  end

  // Sign-magnitude folded into a signed key; flushed zeros of either sign map to 0.
  logic signed [32:0] w_ka, w_kb;
  logic [31:0]        w_cmp_val;

  assign w_ka = w_a_zero ? 33'sd0 :
                (w_sa ? -$signed({2'b00, a[30:0]}) : $signed({2'b00, a[30:0]}));
  assign w_kb = w_b_zero ? 33'sd0 :
                (w_sb ? -$signed({2'b00, b[30:0]}) : $signed({2'b00, b[30:0]}));

  always_comb begin
    if (w_a_nan || w_b_nan)  w_cmp_val = 32'h00000002;
    else if (w_ka < w_kb)    w_cmp_val = 32'hFFFFFFFF;
    else if (w_ka > w_kb)    w_cmp_val = 32'h00000001;
    else                     w_cmp_val = 32'h0;
  end

  always_comb begin
    w_next = 32'h0;
    case (fpu_op)
      OP_MUL:   w_next = w_mul_val;
      OP_FLOOR: w_next = w_floor_val;
      OP_F2I:   w_next = w_fi_val;
      OP_CMP:   w_next = w_cmp_val;
      default:  w_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_result <= 32'h0;
    else     r_result <= w_next;
  end

  assign result = r_result;

endmodule

// File: tb/tb_fpu.sv
// Bench for fpu: directed vector table, random ops against a real-arithmetic model,
// plus async-reset and back-to-back latency sequences.
module tb_fpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  fpu_op;
  logic [31:0] result;

  fpu dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .fpu_op (fpu_op),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          have_pend = 1'b0;
  vec_t        pend;

  task automatic add(input logic [2:0] op, input logic [31:0] va, vb, ve);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.exp = ve;
    tbl.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] got, want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic check_pend();
    string tag;
    tag = $sformatf("op%0d a=%h b=%h", pend.op, pend.a, pend.b);
    check(tag, result, pend.exp);
  endtask

  // Drive at negedge; the op issued one cycle earlier is checked at the same point.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, vb, ve);
    @(negedge clk);
    if (have_pend) check_pend();
    fpu_op = op; a = va; b = vb;
    pend.op = op; pend.a = va; pend.b = vb; pend.exp = ve;
    have_pend = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    if (have_pend) check_pend();
    have_pend = 1'b0;
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real dec(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] enc(input real v);
    logic   s;
    real    m, sc, fl, d;
    int     e;
    longint iv;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc = m * 8388608.0;
    fl = $floor(sc);
    iv = longint'(fl);
    d  = sc - fl;
    if (d > 0.5 || (d == 0.5 && iv[0])) iv++;
    if (iv == 64'd16777216) begin iv = 64'd8388608; e++; end
    if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
    if (e + 127 <= 0)   return {s, 31'd0};
    return {s, 8'(e + 127), iv[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, y);
    bit  nx, ny, ix, iy, zx, zy;
    real vx, vy, f;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:23] == 8'd0);
    zy = (y[30:23] == 8'd0);
    case (op)
      3'd0: begin
        if (nx || ny) return 32'h7FC00000;
        if (ix || iy) return (zx || zy) ? 32'h7FC00000 : {x[31] ^ y[31], 8'hFF, 23'd0};
        if (zx || zy) return {x[31] ^ y[31], 31'd0};
        return enc(dec(x) * dec(y));
      end
      3'd1: begin
        if (nx) return 32'h7FC00000;
        if (ix) return x;
        if (zx) return {x[31], 31'd0};
        f = $floor(dec(x));
        return (f == 0.0) ? 32'h0 : enc(f);
      end
      3'd2: begin
        if (nx || zx) return 32'h0;
        if (ix) return x[31] ? 32'h80000000 : 32'h7FFFFFFF;
        f = $floor(dec(x));
        if (f >= 2147483648.0) return 32'h7FFFFFFF;
        if (f < -2147483648.0) return 32'h80000000;
        return 32'(longint'(f));
      end
      3'd3: begin
        if (nx || ny) return 32'h2;
        vx = ix ? (x[31] ? -1.0e300 : 1.0e300) : dec(x);
        vy = iy ? (y[31] ? -1.0e300 : 1.0e300) : dec(y);
        if (vx < vy) return 32'hFFFFFFFF;
        if (vx > vy) return 32'h1;
        return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp[6];
    int k;
    sp[0] = 32'h0;        sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC00000; sp[5] = 32'h00000123;
    k = $urandom_range(0, 9);
    if (k == 0) return sp[$urandom_range(0, 5)];
    if (k == 1) return $urandom;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)), 23'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // mul
    add(3'd0, 32'h40200000, 32'h40800000, 32'h41200000);
    add(3'd0, 32'hBF800000, 32'h3F800000, 32'hBF800000);
    add(3'd0, 32'h00000000, 32'h3F800000, 32'h00000000);
    add(3'd0, 32'hFF800000, 32'h3F800000, 32'hFF800000);
    add(3'd0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
    add(3'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000);
    add(3'd0, 32'h7F000000, 32'h40000000, 32'h7F800000);
    add(3'd0, 32'h00800000, 32'h3F000000, 32'h00000000);
    add(3'd0, 32'h3FC00000, 32'h3F800001, 32'h3FC00002);
    add(3'd0, 32'h3FC00000, 32'h3F800003, 32'h3FC00004);
    add(3'd0, 32'h3F800001, 32'h3F800001, 32'h3F800002);
    // floor
    add(3'd1, 32'h40BC0000, 32'h0, 32'h40A00000);
    add(3'd1, 32'hBF99999A, 32'h0, 32'hC0000000);
    add(3'd1, 32'h3F000000, 32'h0, 32'h00000000);
    add(3'd1, 32'h80000000, 32'h0, 32'h80000000);
    add(3'd1, 32'h7F800000, 32'h0, 32'h7F800000);
    add(3'd1, 32'h7FC00000, 32'h0, 32'h7FC00000);
    add(3'd1, 32'hBF000000, 32'h0, 32'hBF800000);
    add(3'd1, 32'h4B000001, 32'h0, 32'h4B000001);
    add(3'd1, 32'hC0600000, 32'h0, 32'hC0800000);
    add(3'd1, 32'hC0200000, 32'h0, 32'hC0400000);
    // floor_to_int
    add(3'd2, 32'h406CCCCD, 32'h0, 32'h00000003);
    add(3'd2, 32'hBE99999A, 32'h0, 32'hFFFFFFFF);
    add(3'd2, 32'hC1A00000, 32'h0, 32'hFFFFFFEC);
    add(3'd2, 32'h3E4CCCCD, 32'h0, 32'h00000000);
    add(3'd2, 32'h4F800000, 32'h0, 32'h7FFFFFFF);
    add(3'd2, 32'h4F000000, 32'h0, 32'h7FFFFFFF);
    add(3'd2, 32'hCF000000, 32'h0, 32'h80000000);
    add(3'd2, 32'hFF800000, 32'h0, 32'h80000000);
    add(3'd2, 32'h7FC00000, 32'h0, 32'h00000000);
    add(3'd2, 32'h80000000, 32'h0, 32'h00000000);
    // compare
    add(3'd3, 32'h40400000, 32'h40800000, 32'hFFFFFFFF);
    add(3'd3, 32'h40A00000, 32'h40800000, 32'h00000001);
    add(3'd3, 32'h3F800000, 32'h3F800000, 32'h00000000);
    add(3'd3, 32'h80000000, 32'h00000000, 32'h00000000);
    add(3'd3, 32'h7FC00000, 32'h00000000, 32'h00000002);
    add(3'd3, 32'h00000000, 32'h7FC00000, 32'h00000002);
    add(3'd3, 32'hBF800000, 32'hC0000000, 32'h00000001);
    add(3'd3, 32'hFF800000, 32'h7F800000, 32'hFFFFFFFF);
    // reserved
    add(3'd7, 32'h40400000, 32'h40800000, 32'h00000000);
    add(3'd4, 32'h40400000, 32'h40800000, 32'h00000000);

    rst = 1'b1; a = 32'h40400000; b = 32'h40800000; fpu_op = 3'd0;
    #1;
    check("reset value", result, 32'h0);
    @(posedge clk); #1;
    check("reset held across edge", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table: each result must appear exactly one edge after issue.
    foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    drain();

    for (int i = 0; i < 800; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      ra  = rand_fp();
      rb  = ($urandom_range(0, 7) == 0) ? {~ra[31] & ra[30:23] == 8'd0, ra[30:0]} : rand_fp();
      issue(rop, ra, rb, model(rop, ra, rb));
    end
    drain();

    // Async reset mid-stream, then first op after release.
    issue(3'd0, 32'h40200000, 32'h40800000, 32'h41200000);
    @(posedge clk); #2;
    check("pre-reset result", result, 32'h41200000);
    have_pend = 1'b0;
    rst = 1'b1;
    #1;
    check("async reset clears", result, 32'h0);
    fpu_op = 3'd1; a = 32'h40BC0000; b = 32'h0;
    @(negedge clk);
    check("reset holds zero", result, 32'h0);
    rst = 1'b0;
    #1;
    check("zero before first edge", result, 32'h0);
    @(posedge clk); #1;
    check("first op after release", result, 32'h40A00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
